// File: rtl/sig_unpack_seq.sv
`default_nettype none
// ============================================================================
// Module   : sig_unpack_seq
// Brief    : Sequential significand unpacker. It extracts the double or single
//            fraction, forms the hidden-bit significand and normalises
//            denormals STEP bits per cycle. Defining SIG_UNPACK_OVERLAP_EN
//            lets a new operand be accepted while the current result is
//            handed off.
// Revision : 1.0 - initial release
// ============================================================================
module sig_unpack_seq #(
    parameter int W    = 64,
    parameter int FW   = 52,
    parameter int SFW  = 23,
    parameter int SOFF = 32,
    parameter int STEP = 8,
    parameter int LZW  = $clog2(FW + 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            db,
    input  logic [W-1:0]    x,
    input  logic            e_z,
    input  logic            normal,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FW:0]     f,
    output logic [LZW-1:0]  lz,
    output logic            fz,
    output logic [FW-1:0]   h
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_NORM = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [1:0]     w_acc_state;
    logic [FW:0]    r_work;
    logic [LZW-1:0] r_lz;
    logic           r_fz;
    logic [FW-1:0]  r_h;

    logic           w_accept;
    logic [FW-1:0]  w_h_single;
    logic [FW-1:0]  w_h;
    logic [FW:0]    w_te;
    logic           w_fz;
    logic           w_te_zero;
    logic [LZW-1:0] w_k;
    logic           w_k_full;
    logic           w_unused_x;

    // Only the fraction fields of x are consumed; the rest is ignored.
    assign w_unused_x = ^x;

    generate
        if (FW > SFW) begin : g_single_pad
            assign w_h_single = {x[SOFF+SFW-1:SOFF], {(FW-SFW){1'b0}}};
        end else begin : g_single_nopad
            assign w_h_single = x[SOFF+SFW-1:SOFF];
        end
    endgenerate

    assign w_h       = db ? x[FW-1:0] : w_h_single;
    assign w_te      = {~e_z, w_h};
    assign w_fz      = (w_h == '0);
    assign w_te_zero = (w_te == '0);
    assign w_accept  = in_valid && in_ready;

    // Only a non-zero significand without the hidden bit needs shifting.
    assign w_acc_state = (normal && !w_te[FW] && !w_te_zero) ? c_NORM : c_DONE;

    // Leading zeros within the top STEP bits of the work register (0..STEP).
    always_comb begin
        w_k = LZW'(STEP);
        for (int i = 0; i < STEP; i++) begin
            if (r_work[FW-STEP+1+i]) begin
                w_k = LZW'(STEP - 1 - i);
            end
        end
    end

    assign w_k_full = (w_k == LZW'(STEP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_acc_state;
                end
            end
            c_NORM: begin
                if (!w_k_full) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_nxt = w_accept ? w_acc_state : c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_IDLE: in_ready = 1'b1;
            c_DONE: begin
                out_valid = 1'b1;
`ifdef SIG_UNPACK_OVERLAP_EN
                in_ready  = out_ready;
`else
                in_ready  = 1'b0;
`endif
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_lz   <= '0;
            r_fz   <= 1'b0;
            r_h    <= '0;
        end else if (w_accept) begin
            r_h  <= w_h;
            r_fz <= w_fz;
            if (normal && w_te_zero) begin
                r_work <= '0;
                r_lz   <= LZW'(FW + 1);
            end else begin
                r_work <= w_te;
                r_lz   <= '0;
            end
        end else if (r_state == c_NORM) begin
            r_work <= r_work << w_k;
            r_lz   <= r_lz + w_k;
        end
    end

    assign f  = r_work;
    assign lz = r_lz;
    assign fz = r_fz;
    assign h  = r_h;

endmodule
`default_nettype wire

// File: tb/tb_sig_unpack_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig_unpack_seq
// Brief    : Directed self-checking bench for sig_unpack_seq (W=64, FW=52).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sig_unpack_seq;

    localparam int W   = 64;
    localparam int FW  = 52;
    localparam int LZW = $clog2(FW + 2);

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           db;
    logic [W-1:0]   x;
    logic           e_z;
    logic           normal;
    logic           out_ready;
    wire            in_ready;
    wire            out_valid;
    wire  [FW:0]    f;
    wire  [LZW-1:0] lz;
    wire            fz;
    wire  [FW-1:0]  h;

    int             checks = 0;
    int             errors = 0;
    int             lat;
    logic [63:0]    rx;
    logic [63:0]    xv;

    sig_unpack_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .db        (db),
        .x         (x),
        .e_z       (e_z),
        .normal    (normal),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .lz        (lz),
        .fz        (fz),
        .h         (h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand for a single accept edge, then count edges until out_valid.
    task automatic run_op(input logic d, input logic [63:0] xin, input logic ez,
                          input logic nm, output int l);
        db       = d;
        x        = xin;
        e_z      = ez;
        normal   = nm;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        l = 1;
        while (out_valid !== 1'b1 && l < 64) begin
            step();
            l++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        db        = 1'b0;
        x         = '0;
        e_z       = 1'b0;
        normal    = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_f",         64'(f),         64'd0);
        check("rst_lz",        64'(lz),        64'd0);
        check("rst_fz",        64'(fz),        64'd0);
        check("rst_h",         64'(h),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Bypass: hidden bit set, te = {1, h}
        run_op(1'b1, 64'h0008_0000_0000_0001, 1'b0, 1'b1, lat);
        check("byp_lat", 64'(lat), 64'd1);
        check("byp_f",   64'(f),   64'h0018_0000_0000_0001);
        check("byp_lz",  64'(lz),  64'd0);
        check("byp_fz",  64'(fz),  64'd0);
        check("byp_h",   64'(h),   64'h0008_0000_0000_0001);
`ifdef SIG_UNPACK_OVERLAP_EN
        check("byp_in_ready_done", 64'(in_ready), 64'd1);
`else
        check("byp_in_ready_done", 64'(in_ready), 64'd0);
`endif
        step();
        check("byp_handoff_valid", 64'(out_valid), 64'd0);

        // Full denormal: 52 leading zeros, 6 full steps then 4
        run_op(1'b1, 64'h1, 1'b1, 1'b1, lat);
        check("den_lat", 64'(lat), 64'd8);
        check("den_f",   64'(f),   64'h0010_0000_0000_0000);
        check("den_lz",  64'(lz),  64'd52);
        check("den_fz",  64'(fz),  64'd0);
        check("den_h",   64'(h),   64'h1);
        step();

        // Exactly STEP leading zeros: one full step then k=0
        run_op(1'b1, 64'h0000_1000_0000_0000, 1'b1, 1'b1, lat);
        check("lz8_lat", 64'(lat), 64'd3);
        check("lz8_f",   64'(f),   64'h0010_0000_0000_0000);
        check("lz8_lz",  64'(lz),  64'd8);
        step();

        // Zero operand
        run_op(1'b1, 64'h0, 1'b1, 1'b1, lat);
        check("zero_lat", 64'(lat), 64'd1);
        check("zero_f",   64'(f),   64'd0);
        check("zero_lz",  64'(lz),  64'd53);
        check("zero_fz",  64'(fz),  64'd1);
        check("zero_h",   64'(h),   64'd0);
        step();

        // Single with random surrounding bits
        rx = {$urandom, $urandom};
        rx[54:32] = 23'h40_0000;
        run_op(1'b0, rx, 1'b1, 1'b1, lat);
        check("sgl_lat", 64'(lat), 64'd2);
        check("sgl_h",   64'(h),   64'h0008_0000_0000_0000);
        check("sgl_lz",  64'(lz),  64'd1);
        check("sgl_f",   64'(f),   64'h0010_0000_0000_0000);
        check("sgl_fz",  64'(fz),  64'd0);
        step();

        // No normalise, then hold the result under backpressure
        out_ready = 1'b0;
        run_op(1'b1, 64'h3, 1'b1, 1'b0, lat);
        check("nn_lat", 64'(lat), 64'd1);
        check("nn_f",   64'(f),   64'h3);
        check("nn_lz",  64'(lz),  64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_f",         64'(f),         64'h3);
            check("bp_lz",        64'(lz),        64'd0);
            check("bp_in_ready",  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready),  64'd1);

        // Asynchronous reset while normalising
        db = 1'b1; x = 64'h1; e_z = 1'b1; normal = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("norm_in_ready",  64'(in_ready),  64'd0);
        check("norm_out_valid", 64'(out_valid), 64'd0);
        step();
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        check("arst_lz",        64'(lz),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_ready", 64'(in_ready),  64'd1);

`ifdef SIG_UNPACK_OVERLAP_EN
        // Four back-to-back bypass operands, one result per cycle
        db = 1'b1; e_z = 1'b0; normal = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xv       = 64'h1 << (i * 4);
            x        = xv;
            in_valid = 1'b1;
            step();
            check("ovl_out_valid", 64'(out_valid), 64'd1);
            check("ovl_f",         64'(f),         64'h0010_0000_0000_0000 | xv);
        end
        in_valid = 1'b0;
        step();
        check("ovl_drain_valid", 64'(out_valid), 64'd0);
`else
        // Held in_valid is not taken while DONE; second accept waits for IDLE
        db = 1'b1; e_z = 1'b0; normal = 1'b1;
        x = 64'h5; in_valid = 1'b1;
        step();
        check("b2b_a_valid", 64'(out_valid), 64'd1);
        check("b2b_a_f",     64'(f),         64'h0010_0000_0000_0005);
        check("b2b_a_ready", 64'(in_ready),  64'd0);
        x = 64'h9;
        step();
        check("b2b_gap_valid", 64'(out_valid), 64'd0);
        check("b2b_gap_ready", 64'(in_ready),  64'd1);
        step();
        in_valid = 1'b0;
        check("b2b_b_valid", 64'(out_valid), 64'd1);
        check("b2b_b_f",     64'(f),         64'h0010_0000_0000_0009);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
